// File: rtl/param_cpu_host.sv
// Small parameterized accumulator-less CPU core: 8 GPRs, RUN/MUL/HALT sequencer,
// handshake-driven instruction fetch, OUT strobe port and registered debug mirrors.
module param_cpu_host #(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 13,
  parameter int BOOT_PC    = 0,
  parameter int MUL_CYCLES = 4,
  parameter int OUT_REG    = 0
) (
  input  logic              clk,
  input  logic              pon_rst_n_i,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              resume,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] reg_data_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              cpu_halt
);

  localparam logic [PC_W-1:0] BOOT     = PC_W'(BOOT_PC);
  localparam logic [2:0]      OREG     = 3'(OUT_REG);
  localparam logic [3:0]      MUL_LAST = 4'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_BEQZ = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_RUN, S_MUL, S_HALT} state_t;

  state_t                  state;
  logic [PC_W-1:0]         pc;
  logic [7:0][DATA_W-1:0]  regs;
  logic [3:0]              mul_cnt;
  logic [2:0]              mul_rd;
  logic [DATA_W-1:0]       mul_a, mul_b;

  logic [3:0]        op;
  logic [2:0]        rd, ra, rb;
  logic [DATA_W-1:0] val_a, val_b, val_d, ldi_val;
  logic [15:0]       br_off, jmp_tgt;
  logic [PC_W-1:0]   pc_inc, pc_br, pc_jmp;
  logic              accept;

  assign op = instruction[15:12];
  assign rd = instruction[11:9];
  assign ra = instruction[8:6];
  assign rb = instruction[5:3];

  // Reads come straight from the flops, so same-cycle writes are never forwarded.
  assign val_a   = regs[ra];
  assign val_b   = regs[rb];
  assign val_d   = regs[rd];
  assign ldi_val = DATA_W'(instruction[7:0]);

  // Offsets/targets are formed at 16 bits and truncated, which gives mod 2^PC_W wrap.
  assign br_off  = {{7{instruction[8]}}, instruction[8:0]};
  assign jmp_tgt = {4'b0000, instruction[11:0]};
  assign pc_inc  = pc + PC_W'(1);
  assign pc_br   = pc + br_off[PC_W-1:0];
  assign pc_jmp  = jmp_tgt[PC_W-1:0];

  assign instr_ready = (state == S_RUN);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      state        <= S_RUN;
      pc           <= BOOT;
      regs         <= '0;
      mul_cnt      <= '0;
      mul_rd       <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      pc_out       <= BOOT;
      reg_data_out <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      cpu_halt     <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      pc_out       <= pc;
      reg_data_out <= regs[OREG];
      case (state)
        S_RUN: begin
          if (accept) begin
            case (op)
              OP_ADD: begin
                regs[rd] <= val_a + val_b;
                pc       <= pc_inc;
              end
              OP_SUB: begin
                regs[rd] <= val_a - val_b;
                pc       <= pc_inc;
              end
              OP_LDI: begin
                regs[rd] <= ldi_val;
                pc       <= pc_inc;
              end
              OP_JMP:  pc <= pc_jmp;
              OP_BEQZ: pc <= (val_d == '0) ? pc_br : pc_inc;
              OP_MUL: begin
                // Operands are latched now; later writes to Ra/Rb don't disturb the result.
                mul_a   <= val_a;
                mul_b   <= val_b;
                mul_rd  <= rd;
                mul_cnt <= MUL_LAST;
                state   <= S_MUL;
              end
              OP_OUT: begin
                out_data  <= val_a;
                out_valid <= 1'b1;
                pc        <= pc_inc;
              end
              OP_HALT: begin
                state    <= S_HALT;
                cpu_halt <= 1'b1;
              end
              default: pc <= pc_inc;
            endcase
          end
        end
        S_MUL: begin
          if (mul_cnt == 4'd0) begin
            regs[mul_rd] <= mul_a * mul_b;
            pc           <= pc_inc;
            state        <= S_RUN;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        S_HALT: begin
          if (resume) begin
            state    <= S_RUN;
            cpu_halt <= 1'b0;
            pc       <= pc_inc;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu_host.sv
// Scoreboarded bench for param_cpu_host: a reference model predicts OUT strobes
// and architectural state; directed cases cover reset, wrap, HALT and MUL abort.
module tb_param_cpu_host;

  localparam int DW = 16;
  localparam int PW = 8;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   instruction = '0;
  logic          instr_valid = 1'b0;
  logic          resume = 1'b0;
  logic          instr_ready;
  logic [PW-1:0] pc_out;
  logic [DW-1:0] reg_data_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          cpu_halt;

  param_cpu_host #(
    .DATA_W(DW), .PC_W(PW), .BOOT_PC(0), .MUL_CYCLES(MC), .OUT_REG(0)
  ) dut (
    .clk(clk), .pon_rst_n_i(rst_n), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .resume(resume),
    .pc_out(pc_out), .reg_data_out(reg_data_out), .out_data(out_data),
    .out_valid(out_valid), .cpu_halt(cpu_halt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] m_r[8];
  logic [PW-1:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h3, rd, 1'b0, imm};
  endfunction

  function automatic logic [15:0] jmp(input logic [11:0] tgt);
    return {4'h4, tgt};
  endfunction

  function automatic logic [15:0] beqz(input logic [2:0] rd, input logic [8:0] off);
    return {4'h5, rd, off};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_pc = '0;
  endtask

  task automatic model_step(input logic [15:0] ins);
    logic [2:0]  rd, ra, rb;
    logic [15:0] off;
    rd  = ins[11:9];
    ra  = ins[8:6];
    rb  = ins[5:3];
    off = {{7{ins[8]}}, ins[8:0]};
    case (ins[15:12])
      4'h1: begin m_r[rd] = m_r[ra] + m_r[rb]; m_pc++; end
      4'h2: begin m_r[rd] = m_r[ra] - m_r[rb]; m_pc++; end
      4'h3: begin m_r[rd] = {8'h00, ins[7:0]}; m_pc++; end
      4'h4: m_pc = ins[PW-1:0];
      4'h5: m_pc = (m_r[rd] == '0) ? m_pc + off[PW-1:0] : m_pc + 1'b1;
      4'h6: begin m_r[rd] = m_r[ra] * m_r[rb]; m_pc++; end
      4'h7: begin sb_q.push_back(m_r[ra]); m_pc++; end
      4'hF: ;
      default: m_pc++;
    endcase
  endtask

  // Waits (bounded) for the core to be ready, presents one instruction for one edge.
  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("ready_timeout", instr_ready, 1'b1);
    instruction = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    model_step(ins);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) chk("out_unexpected", out_valid, 1'b0);
      else chk("out_data", out_data, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [DW-1:0] old;
    model_reset();

    // Reset values while held in reset
    #12;
    chk("rst_pc", pc_out, 0);
    chk("rst_rdo", reg_data_out, 0);
    chk("rst_outd", out_data, 0);
    chk("rst_outv", out_valid, 0);
    chk("rst_halt", cpu_halt, 0);
    chk("rst_ready", instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // LDI/LDI/ADD into R0 (mirrored register)
    issue(ldi(3'd1, 8'd5));
    issue(ldi(3'd2, 8'd3));
    issue(enc_r(4'h1, 3'd0, 3'd1, 3'd2));
    settle();
    chk("add_rdo", reg_data_out, 16'd8);
    chk("add_pc", pc_out, 3);

    // MUL latency and result through OUT
    issue(ldi(3'd1, 8'hFF));
    issue(ldi(3'd2, 8'hFF));
    issue(enc_r(4'h6, 3'd3, 3'd1, 3'd2));
    cnt = 0;
    @(negedge clk);
    while (!instr_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", cnt, MC);
    issue(enc_r(4'h7, 3'd0, 3'd3, 3'd0));
    @(negedge clk);
    chk("out_vld_hi", out_valid, 1);
    chk("out_r3", out_data, 16'hFE01);
    @(negedge clk);
    chk("out_vld_lo", out_valid, 0);

    // SUB underflow
    issue(ldi(3'd0, 8'd0));
    issue(ldi(3'd1, 8'd1));
    issue(enc_r(4'h2, 3'd4, 3'd0, 3'd1));
    issue(enc_r(4'h7, 3'd0, 3'd4, 3'd0));
    settle();
    chk("sub_r4", out_data, 16'hFFFF);

    // BEQZ taken backwards, then not taken
    issue(jmp(12'd10));
    issue(beqz(3'd5, 9'h1FE));
    settle();
    chk("beqz_taken", pc_out, 8);
    issue(beqz(3'd4, 9'h1FE));
    settle();
    chk("beqz_not_taken", pc_out, 9);

    // JMP truncation and PC wrap
    issue(jmp(12'hFFF));
    settle();
    chk("jmp_trunc", pc_out, 8'hFF);
    issue(16'h0000);
    settle();
    chk("nop_wrap", pc_out, 0);

    // HALT / resume
    issue(jmp(12'd6));
    issue(16'hF000);
    @(negedge clk);
    chk("halt_flag", cpu_halt, 1);
    chk("halt_ready", instr_ready, 0);
    instruction = ldi(3'd6, 8'h77);
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_pc", pc_out, 6);
    chk("halt_hold", cpu_halt, 1);
    instr_valid = 1'b0;
    resume = 1'b1;
    @(posedge clk);
    #1 resume = 1'b0;
    m_pc++;
    @(negedge clk);
    chk("resume_flag", cpu_halt, 0);
    @(negedge clk);
    chk("resume_pc", pc_out, 7);
    issue(enc_r(4'h7, 3'd0, 3'd6, 3'd0));

    // Resume while running is ignored
    @(negedge clk);
    resume = 1'b1;
    @(posedge clk);
    #1 resume = 1'b0;
    settle();
    chk("resume_in_run", pc_out, m_pc);

    // Random ALU/MUL traffic, results observed through OUT
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a, b, d;
      logic [3:0] op;
      int k;
      a = 3'($urandom_range(1, 7));
      b = 3'($urandom_range(1, 7));
      d = 3'($urandom_range(0, 7));
      k = $urandom_range(0, 2);
      op = (k == 0) ? 4'h1 : (k == 1) ? 4'h2 : 4'h6;
      issue(ldi(a, 8'($urandom)));
      issue(ldi(b, 8'($urandom)));
      issue(enc_r(op, d, a, b));
      issue(enc_r(4'h7, 3'd0, d, 3'd0));
    end

    // reg_data_out lag, then reset in the middle of a MUL
    old = m_r[0];
    issue(ldi(3'd0, 8'h5A));
    @(negedge clk);
    chk("rdo_lag1", reg_data_out, old);
    @(negedge clk);
    chk("rdo_lag2", reg_data_out, 16'h005A);
    issue(enc_r(4'h7, 3'd0, 3'd0, 3'd0));
    issue(ldi(3'd1, 8'd3));
    issue(ldi(3'd2, 8'd5));
    issue(enc_r(4'h6, 3'd7, 3'd1, 3'd2));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_pc", pc_out, 0);
    chk("mrst_rdo", reg_data_out, 0);
    chk("mrst_outd", out_data, 0);
    chk("mrst_outv", out_valid, 0);
    chk("mrst_halt", cpu_halt, 0);
    chk("mrst_ready", instr_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue(enc_r(4'h7, 3'd0, 3'd7, 3'd0));
    settle();
    chk("mrst_r7_pc", pc_out, 1);
    issue(enc_r(4'h7, 3'd0, 3'd0, 3'd0));
    settle();

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_cpu_host.md
PARAM_CPU_HOST -- requirements
Module: param_cpu_host

Interface
REQ-001 Parameter DATA_W, default 16: register/datapath width; legal range 8..32.
REQ-002 Parameter PC_W, default 13: program-counter width; legal range 8..16.
REQ-003 Parameter BOOT_PC, default 0: PC value loaded on reset, truncated to PC_W.
REQ-004 Parameter MUL_CYCLES, default 4: MUL execute latency in cycles; legal range 1..16.
REQ-005 Parameter OUT_REG, default 0: index 0..7 of the register mirrored on reg_data_out.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 pon_rst_n_i  input  1  reset, asynchronous, active-low.
REQ-008 instruction  input  16  instruction word: opcode [15:12], rd [11:9], ra [8:6], rb [5:3].
REQ-009 instr_valid  input  1  instruction is present.
REQ-010 instr_ready  output  1  core accepts an instruction this cycle; combinational, high only in RUN.
REQ-011 resume  input  1  single-cycle pulse that leaves HALT.
REQ-012 pc_out  output  PC_W  registered copy of the PC.
REQ-013 reg_data_out  output  DATA_W  registered copy of register OUT_REG.
REQ-014 out_data  output  DATA_W  value written by the OUT opcode.
REQ-015 out_valid  output  1  one-cycle strobe qualifying out_data.
REQ-016 cpu_halt  output  1  high while in HALT.

Function
REQ-017 The core SHALL hold eight DATA_W registers R0..R7, a PC_W PC and a state machine with states RUN, MUL and HALT.
REQ-018 An instruction SHALL be accepted only on a cycle with instr_valid && instr_ready; instruction on other cycles is ignored.
REQ-019 Opcode 0 (NOP), 8..E, and any unlisted opcode: PC <= PC+1.
REQ-020 Opcode 1 ADD: Rd <= (Ra+Rb) mod 2^DATA_W; PC+1.
REQ-021 Opcode 2 SUB: Rd <= (Ra-Rb) mod 2^DATA_W; PC+1.
REQ-022 Opcode 3 LDI: Rd <= zero-extended instruction[7:0]; PC+1.
REQ-023 Opcode 4 JMP: PC <= zero-extended instruction[11:0], truncated to PC_W.
REQ-024 Opcode 5 BEQZ: if R[11:9]==0 then PC <= PC + sign-extended instruction[8:0], else PC+1.
REQ-025 Opcode 6 MUL: operands Ra and Rb are captured at acceptance; state RUN->MUL for MUL_CYCLES cycles with instr_ready low; on the last MUL cycle Rd <= low DATA_W bits of the product and PC+1; state returns to RUN.
REQ-026 Opcode 7 OUT: out_data <= Ra and out_valid=1 on the next cycle only; PC+1.
REQ-027 Opcode F HALT: state -> HALT; PC is unchanged; cpu_halt=1 from the next cycle.
REQ-028 In HALT a resume pulse SHALL return the state to RUN and set PC <= PC+1; resume in RUN or MUL is ignored.
REQ-029 All PC arithmetic SHALL wrap modulo 2^PC_W.
REQ-030 All register reads SHALL return the pre-write value; a write and a read of the same register in one cycle return the old value.
REQ-031 pc_out and reg_data_out SHALL lag internal state by exactly one cycle.
REQ-032 A write to R0..R7 SHALL be visible on reg_data_out (when rd==OUT_REG) two cycles after acceptance, or two cycles after the last MUL cycle for MUL.

Reset
REQ-033 Assertion of pon_rst_n_i SHALL immediately set: state RUN, PC=BOOT_PC, R0..R7=0, pc_out=BOOT_PC, reg_data_out=0, out_data=0, out_valid=0, cpu_halt=0.
REQ-034 Reset during MUL SHALL abort the operation with no register write.
REQ-035 After deassertion the core SHALL accept an instruction on the first clock edge.

Verification
REQ-036 LDI R1,5; LDI R2,3; ADD R0,R1,R2 with OUT_REG=0 -> reg_data_out=8; pc_out=3.
REQ-037 LDI R1,0xFF; LDI R2,0xFF; MUL R3,R1,R2 -> instr_ready low for 4 cycles; R3=0xFE01; OUT R3 -> out_valid one cycle with out_data=0xFE01.
REQ-038 SUB R4,R0,R1 with R0=0, R1=1 -> R4=0xFFFF; BEQZ on R5=0 with offset -2 at PC=10 -> PC=8.
REQ-039 JMP 0xFFF with PC_W=8 -> PC=0xFF; NOP -> PC=0x00.
REQ-040 HALT at PC=6 -> cpu_halt=1 and instr_ready=0; instr_valid held high has no effect; resume -> cpu_halt=0, PC=7.
REQ-041 Reset asserted on the 2nd MUL cycle -> all outputs at their reset values; Rd is 0.
